signed_scroll_display: RTL and testbench



---
 rtl/display_pkg.sv | 33 +++
 rtl/signed_scroll_display_bin2bcd.sv | 55 +++++
 rtl/signed_scroll_display.sv | 160 ++++++++++++++++
 tb/tb_signed_scroll_display.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the signed seven-segment scroll display.
//   - digit codes beyond 0-9 (blank, minus)
//   - active-low segment constants, seg[6:0] = g..a
//   - conversion FSM state type
//   - seg_decode(): 4-bit digit code -> active-low segment pattern
package display_pkg;

  localparam logic [3:0] DIG_BLANK = 4'hA;
  localparam logic [3:0] DIG_MINUS = 4'hB;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0:      return 7'b1000000;
      4'd1:      return 7'b1111001;
      4'd2:      return 7'b0100100;
      4'd3:      return 7'b0110000;
      4'd4:      return 7'b0011001;
      4'd5:      return 7'b0010010;
      4'd6:      return 7'b0000010;
      4'd7:      return 7'b1111000;
      4'd8:      return 7'b0000000;
      4'd9:      return 7'b0010000;
      DIG_MINUS: return SEG_MINUS;
      default:   return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/signed_scroll_display_bin2bcd.sv
// Serial binary -> BCD converter (double dabble, one magnitude bit per cycle).
//   clk2, rst : clock, async active-high reset
//   start     : load mag and begin a BIN_W-cycle conversion (may restart)
//   mag       : unsigned magnitude
//   busy      : shifts still outstanding
//   done      : the final shift happens at the coming edge; bcd is final after it
//   bcd       : BCD_DIGITS packed nibbles, digit 0 in bcd[3:0]
module bin2bcd_seq #(
  parameter int BIN_W      = 16,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk2,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        mag,
  output logic                    busy,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]                 r_sr;
  logic [BCD_DIGITS-1:0][3:0]       r_bcd;
  logic [CNT_W-1:0]                 r_cnt;
  logic [BCD_DIGITS-1:0][3:0]       w_adj;
  logic [4*BCD_DIGITS-1:0]          w_adj_flat;

  // add-3 correction per nibble, ahead of the shift
  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_adj
    assign w_adj[d] = (r_bcd[d] >= 4'd5) ? r_bcd[d] + 4'd3 : r_bcd[d];
  end
  assign w_adj_flat = w_adj;

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      r_sr  <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_sr  <= mag;
      r_bcd <= '0;
      r_cnt <= CNT_W'(BIN_W);
    end else if (r_cnt != '0) begin
      r_bcd <= {w_adj_flat[4*BCD_DIGITS-2:0], r_sr[BIN_W-1]};
      r_sr  <= r_sr << 1;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign busy = (r_cnt != '0);
  assign done = (r_cnt == CNT_W'(1));
  assign bcd  = r_bcd;

endmodule

// File: rtl/signed_scroll_display.sv
// Signed decimal display controller: samples a two's-complement value on
// load, converts it serially to BCD, and scans a scrollable WIN-digit window
// plus a sign digit onto WIN+1 active-low anodes.
//   clk2, rst            : clock, async active-high reset
//   bin, load            : value and single-cycle convert request
//   btn_left, btn_right  : single-cycle scroll pulses
//   busy                 : conversion in progress
//   more_left            : nonzero digit exists above the visible window
//   an, seg              : active-low anodes (an[WIN] = sign) and segments g..a
module signed_scroll_display
  import display_pkg::*;
#(
  parameter int BIN_W       = 16,
  parameter int BCD_DIGITS  = 5,
  parameter int WIN         = 3,
  parameter int REFRESH_DIV = 250000,
  parameter int BLANK_LZ    = 1
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin,
  input  logic             load,
  input  logic             btn_left,
  input  logic             btn_right,
  output logic             busy,
  output logic             more_left,
  output logic [WIN:0]     an,
  output logic [6:0]       seg
);

  localparam int OFF_MAX_I = BCD_DIGITS - WIN;
  localparam int OFF_W     = (OFF_MAX_I < 1) ? 1 : $clog2(OFF_MAX_I + 1);
  localparam int DIV_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SCAN_W    = $clog2(WIN + 1);
  localparam logic [OFF_W-1:0]  OFF_MAX  = OFF_W'(OFF_MAX_I);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(WIN);

  conv_state_t                r_state;
  logic                       r_pending, r_sign_cap, r_disp_sign;
  logic [BCD_DIGITS-1:0][3:0] r_disp;
  logic [OFF_W-1:0]           r_off;
  logic [DIV_W-1:0]           r_div;
  logic [SCAN_W-1:0]          r_scan;

  logic                       w_sign, w_start, w_sub_busy, w_done;
  logic [BIN_W-1:0]           w_mag;
  logic [4*BCD_DIGITS-1:0]    w_bcd;
  logic [BCD_DIGITS-1:0][3:0] w_code;
  logic [SCAN_W-1:0]          w_scan_nxt;
  logic [3:0]                 w_nxt_code;
  logic [WIN:0]               w_an_nxt;

  // sign/magnitude of the live input; ~x+1 also maps the most negative value
  // onto its correct unsigned magnitude
  assign w_sign = bin[BIN_W-1];
  assign w_mag  = w_sign ? (~bin + BIN_W'(1)) : bin;

  // a load arriving in the commit cycle is folded into the pending restart
  assign w_start = ((r_state == S_IDLE) && load) ||
                   ((r_state == S_COMMIT) && (r_pending || load));

  bin2bcd_seq #(.BIN_W(BIN_W), .BCD_DIGITS(BCD_DIGITS)) u_conv (
    .clk2  (clk2),
    .rst   (rst),
    .start (w_start),
    .mag   (w_mag),
    .busy  (w_sub_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  assign busy = w_sub_busy || (r_state == S_COMMIT);

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_sign_cap  <= 1'b0;
      r_disp_sign <= 1'b0;
      r_disp      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (load) begin
          r_sign_cap <= w_sign;
          r_state    <= S_CONV;
        end
        S_CONV: begin
          if (load) r_pending <= 1'b1;
          if (w_done) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_disp      <= w_bcd;
          r_disp_sign <= r_sign_cap && (w_bcd != '0);
          r_pending   <= 1'b0;
          if (r_pending || load) begin
            r_sign_cap <= w_sign;
            r_state    <= S_CONV;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst)
      r_off <= '0;
    else if (btn_left && !btn_right && r_off != OFF_MAX)
      r_off <= r_off + 1'b1;
    else if (btn_right && !btn_left && r_off != '0)
      r_off <= r_off - 1'b1;
  end

  // per-digit display code with leading-zero blanking; digit 0 always numeric
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    w_code    = r_disp;
    more_left = 1'b0;
    for (int j = BCD_DIGITS - 1; j >= 0; j--) begin
      all_zero = all_zero && (r_disp[j] == 4'd0);
      if (BLANK_LZ != 0 && j != 0 && all_zero) w_code[j] = DIG_BLANK;
      if (j >= int'(r_off) + WIN && r_disp[j] != 4'd0) more_left = 1'b1;
    end
  end

  // content for the scan position that becomes active at the next advance
  always_comb begin
    w_scan_nxt = (r_scan == SCAN_MAX) ? '0 : r_scan + 1'b1;
    w_nxt_code = DIG_BLANK;
    if (w_scan_nxt == SCAN_MAX) begin
      w_nxt_code = r_disp_sign ? DIG_MINUS : DIG_BLANK;
    end else begin
      for (int j = 0; j < BCD_DIGITS; j++)
        if (j == int'(r_off) + int'(w_scan_nxt)) w_nxt_code = w_code[j];
    end
    w_an_nxt = '1;
    w_an_nxt[w_scan_nxt] = 1'b0;
  end

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_scan <= '0;
      an     <= ~(WIN+1)'(1);
      seg    <= 7'b1000000;
    end else if (r_div == DIV_LAST) begin
      r_div  <= '0;
      r_scan <= w_scan_nxt;
      an     <= w_an_nxt;
      seg    <= seg_decode(w_nxt_code);
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: tb/tb_signed_scroll_display.sv
module tb_signed_scroll_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S6 = 7'b0000010,
                         S7 = 7'b1111000, S8 = 7'b0000000, SB = 7'b1111111,
                         SM = 7'b0111111;

  logic        clk2 = 1'b0, rst = 1'b1;
  logic [15:0] bin = '0;
  logic        load = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        busy, more_left;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_pass = 0, n_total = 0;

  signed_scroll_display #(
    .BIN_W(16), .BCD_DIGITS(5), .WIN(3), .REFRESH_DIV(4), .BLANK_LZ(1)
  ) dut (
    .clk2(clk2), .rst(rst), .bin(bin), .load(load),
    .btn_left(btn_left), .btn_right(btn_right),
    .busy(busy), .more_left(more_left), .an(an), .seg(seg)
  );

  always #5 clk2 = ~clk2;

  // all tasks start and end 1 time unit after a rising edge
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk2); #1; end
  endtask

  task automatic do_load(input logic [15:0] v);
    bin = v; load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  task automatic press(input logic l, input logic r);
    btn_left = l; btn_right = r;
    tick(1);
    btn_left = 1'b0; btn_right = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick(1);
      if (!busy) ok = 1'b1;
    end
  endtask

  // let the registered scan catch up, then grab seg while position p is lit
  task automatic read_pos(input int p, output logic [6:0] s, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << p);
    ok = 1'b0; s = 'x;
    tick(5);
    for (int i = 0; i < 24 && !ok; i++) begin
      tick(1);
      if (an === want) begin ok = 1'b1; s = seg; end
    end
  endtask

  task automatic test_reset;
    tick(2);
    n_total++; if (busy !== 1'b0) $display("FAIL rst_busy act=%b exp=0", busy); else n_pass++;
    n_total++; if (more_left !== 1'b0) $display("FAIL rst_more_left act=%b exp=0", more_left); else n_pass++;
    n_total++; if (an !== 4'b1110) $display("FAIL rst_an act=%b exp=1110", an); else n_pass++;
    n_total++; if (seg !== S0) $display("FAIL rst_seg act=%b exp=%b", seg, S0); else n_pass++;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_convert;
    logic [6:0] s; bit ok;
    do_load(16'h04D2);                 // now at edge k
    n_total++; if (busy !== 1'b1) $display("FAIL conv_busy_rise act=%b exp=1", busy); else n_pass++;
    tick(16);                          // edge k+16
    n_total++; if (busy !== 1'b1) $display("FAIL conv_busy_k16 act=%b exp=1", busy); else n_pass++;
    n_total++; if (more_left !== 1'b0) $display("FAIL conv_no_partial act=%b exp=0", more_left); else n_pass++;
    tick(1);                           // edge k+17
    n_total++; if (busy !== 1'b0) $display("FAIL conv_busy_fall act=%b exp=0", busy); else n_pass++;
    n_total++; if (more_left !== 1'b1) $display("FAIL conv_more_left act=%b exp=1", more_left); else n_pass++;
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S4) $display("FAIL conv_pos0 act=%b exp=%b", s, S4); else n_pass++;
    read_pos(1, s, ok);
    n_total++; if (!ok || s !== S3) $display("FAIL conv_pos1 act=%b exp=%b", s, S3); else n_pass++;
    read_pos(2, s, ok);
    n_total++; if (!ok || s !== S2) $display("FAIL conv_pos2 act=%b exp=%b", s, S2); else n_pass++;
    read_pos(3, s, ok);
    n_total++; if (!ok || s !== SB) $display("FAIL conv_sign act=%b exp=%b", s, SB); else n_pass++;
  endtask

  task automatic test_scroll;
    logic [6:0] s; bit ok;
    press(1'b1, 1'b0);                 // offset 1: 3,2,1
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S3) $display("FAIL scr1_pos0 act=%b exp=%b", s, S3); else n_pass++;
    read_pos(2, s, ok);
    n_total++; if (!ok || s !== S1) $display("FAIL scr1_pos2 act=%b exp=%b", s, S1); else n_pass++;
    press(1'b1, 1'b0);                 // offset 2: blank,1,2
    n_total++; if (more_left !== 1'b0) $display("FAIL scr2_more_left act=%b exp=0", more_left); else n_pass++;
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S2) $display("FAIL scr2_pos0 act=%b exp=%b", s, S2); else n_pass++;
    read_pos(1, s, ok);
    n_total++; if (!ok || s !== S1) $display("FAIL scr2_pos1 act=%b exp=%b", s, S1); else n_pass++;
    read_pos(2, s, ok);
    n_total++; if (!ok || s !== SB) $display("FAIL scr2_pos2 act=%b exp=%b", s, SB); else n_pass++;
    press(1'b1, 1'b0);                 // saturates
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S2) $display("FAIL scr_sat_hi act=%b exp=%b", s, S2); else n_pass++;
    press(1'b1, 1'b1);                 // both: no change
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S2) $display("FAIL scr_both act=%b exp=%b", s, S2); else n_pass++;
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);                 // saturates at 0
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S4) $display("FAIL scr_sat_lo act=%b exp=%b", s, S4); else n_pass++;
    n_total++; if (more_left !== 1'b1) $display("FAIL scr_lo_more_left act=%b exp=1", more_left); else n_pass++;
  endtask

  task automatic test_negative;
    logic [6:0] s; bit ok;
    do_load(16'hFB2E);
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL neg_timeout act=busy exp=idle"); else n_pass++;
    read_pos(3, s, ok);
    n_total++; if (!ok || s !== SM) $display("FAIL neg_sign act=%b exp=%b", s, SM); else n_pass++;
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S4) $display("FAIL neg_pos0 act=%b exp=%b", s, S4); else n_pass++;
    read_pos(2, s, ok);
    n_total++; if (!ok || s !== S2) $display("FAIL neg_pos2 act=%b exp=%b", s, S2); else n_pass++;
  endtask

  task automatic test_extremes;
    logic [6:0] s; bit ok;
    do_load(16'h8000);                 // -32768
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL min_timeout act=busy exp=idle"); else n_pass++;
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S8) $display("FAIL min_pos0 act=%b exp=%b", s, S8); else n_pass++;
    read_pos(1, s, ok);
    n_total++; if (!ok || s !== S6) $display("FAIL min_pos1 act=%b exp=%b", s, S6); else n_pass++;
    read_pos(3, s, ok);
    n_total++; if (!ok || s !== SM) $display("FAIL min_sign act=%b exp=%b", s, SM); else n_pass++;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);                 // offset 2: 3,2,7
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S7) $display("FAIL min_off2_pos0 act=%b exp=%b", s, S7); else n_pass++;
    read_pos(2, s, ok);
    n_total++; if (!ok || s !== S3) $display("FAIL min_off2_pos2 act=%b exp=%b", s, S3); else n_pass++;
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    do_load(16'h0000);
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL zero_timeout act=busy exp=idle"); else n_pass++;
    n_total++; if (more_left !== 1'b0) $display("FAIL zero_more_left act=%b exp=0", more_left); else n_pass++;
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S0) $display("FAIL zero_pos0 act=%b exp=%b", s, S0); else n_pass++;
    read_pos(1, s, ok);
    n_total++; if (!ok || s !== SB) $display("FAIL zero_pos1 act=%b exp=%b", s, SB); else n_pass++;
    read_pos(2, s, ok);
    n_total++; if (!ok || s !== SB) $display("FAIL zero_pos2 act=%b exp=%b", s, SB); else n_pass++;
    read_pos(3, s, ok);
    n_total++; if (!ok || s !== SB) $display("FAIL zero_sign act=%b exp=%b", s, SB); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [6:0] s, exp_s; bit ok; int p;
    logic [6:0] exp100 [4];
    exp100[0] = S0; exp100[1] = S0; exp100[2] = S1; exp100[3] = SB;
    do_load(16'h0064);                 // edge k
    tick(4);
    do_load(16'hFFFF);                 // edge k+5, sets pending
    tick(11);                          // edge k+16
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_busy_k16 act=%b exp=1", busy); else n_pass++;
    tick(1);                           // edge k+17: 100 committed, restart
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_busy_k17 act=%b exp=1", busy); else n_pass++;
    tick(8);                           // edge k+25: scan content reflects 100
    p = -1;
    for (int i = 0; i < 4; i++) if (an === ~(4'b0001 << i)) p = i;
    exp_s = (p >= 0) ? exp100[p] : 7'bx;
    n_total++; if (p < 0 || seg !== exp_s) $display("FAIL b2b_show100 pos=%0d act=%b exp=%b", p, seg, exp_s); else n_pass++;
    tick(8);                           // edge k+33
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_busy_k33 act=%b exp=1", busy); else n_pass++;
    tick(1);                           // edge k+34
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_busy_k34 act=%b exp=0", busy); else n_pass++;
    read_pos(3, s, ok);
    n_total++; if (!ok || s !== SM) $display("FAIL b2b_sign act=%b exp=%b", s, SM); else n_pass++;
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S1) $display("FAIL b2b_pos0 act=%b exp=%b", s, S1); else n_pass++;
    read_pos(1, s, ok);
    n_total++; if (!ok || s !== SB) $display("FAIL b2b_pos1 act=%b exp=%b", s, SB); else n_pass++;
  endtask

  task automatic test_mid_reset;
    logic [6:0] s; bit ok;
    press(1'b1, 1'b0);                 // offset 1 before reset
    do_load(16'h04D2);                 // edge k
    tick(7);                           // edge k+7
    rst = 1'b1;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL mrst_busy act=%b exp=0", busy); else n_pass++;
    n_total++; if (an !== 4'b1110) $display("FAIL mrst_an act=%b exp=1110", an); else n_pass++;
    n_total++; if (seg !== S0) $display("FAIL mrst_seg act=%b exp=%b", seg, S0); else n_pass++;
    n_total++; if (more_left !== 1'b0) $display("FAIL mrst_more_left act=%b exp=0", more_left); else n_pass++;
    tick(2);
    rst = 1'b0;
    tick(1);
    do_load(16'h04D2);
    wait_idle(ok);
    n_total++; if (!ok) $display("FAIL mrst_timeout act=busy exp=idle"); else n_pass++;
    n_total++; if (more_left !== 1'b1) $display("FAIL mrst_reload_more act=%b exp=1", more_left); else n_pass++;
    read_pos(0, s, ok);
    n_total++; if (!ok || s !== S4) $display("FAIL mrst_off0_pos0 act=%b exp=%b", s, S4); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_convert;
    test_scroll;
    test_negative;
    test_extremes;
    test_back_to_back;
    test_mid_reset;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
